seq_mult16_ctrl: RTL and testbench
==================================

Name: seq_mult16_ctrl

Overview:
- Iterative shift-and-add multiplier controller. It sequences one shared WIDTH-bit ripple-carry adder, built from full-adder cells, over WIDTH cycles to form an unsigned WIDTH x WIDTH product.
- Low-area alternative to the Dadda array multiplier, with the same unsigned operands and the same 2*WIDTH-bit result format.
- Uses a valid/ready handshake on both the operand side and the result side.

Parameters:
- WIDTH, 16, operand width in bits; product is 2*WIDTH bits; legal range 2 to 32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands a and b are valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  p holds a completed product.
- out_ready  input  1  consumer accepts p.
- p  output  2*WIDTH  product register.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, in_ready=1, out_valid=0, busy=0, p=0, iteration counter=0.
  - Reset mid-RUN or mid-DONE abandons the operation; no result is produced.
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid&&in_ready: latch mcand<=a, acc<={WIDTH'b0, b}, cnt<=WIDTH-1, then go to RUN.
  - RUN, one iteration per cycle:
    - sum[WIDTH:0] = acc[2W-1:W] + (acc[0] ? mcand : 0), through the shared adder; the carry-out is kept.
    - acc <= {sum[WIDTH:0], acc[W-1:1]}, i.e. a right shift by one with the carry entering at the MSB.
    - If cnt==0, go to DONE; otherwise cnt<=cnt-1.
  - DONE:
    - out_valid=1, p=acc.
    - Hold p and out_valid stable until out_ready=1.
    - On out_valid&&out_ready, go to IDLE. out_valid drops the next cycle, and p retains its last value.
- Latency:
  - Accept at edge N; RUN occupies edges N+1 to N+WIDTH; out_valid=1 from the cycle after edge N+WIDTH.
  - This gives WIDTH+1 cycles from accept to out_valid (17 for WIDTH=16).
- Throughput: one product per WIDTH+2 cycles when out_ready is held high. There is no accept in the same cycle as a result hand-off.
- Back-pressure: out_ready low holds DONE indefinitely; in_ready stays 0 throughout.
- in_valid while not in IDLE is ignored; the source must hold its operands until in_ready.
- Arithmetic is exact: p = a*b mod 2^(2*WIDTH), which never wraps because the maximum product fits. Example: 0xFFFF*0xFFFF = 0xFFFE0001.
- The adder carry-out must be captured every cycle; dropping it is a defect.
- a and b are sampled only at the accept edge; later changes must not affect the result.

Optional Feature:
- Macro: SEQ_MULT_ZERO_BYPASS_EN.
- Defined:
  - At accept, if a==0 or b==0, skip RUN and go directly IDLE->DONE with acc=0.
  - out_valid is then asserted 1 cycle after accept.
  - All other operands behave as above.
- Undefined: every operation takes the full WIDTH+1 cycle latency, with no operand inspection.

Decomposition:
- Package seq_mult_pkg holds:
  - state enum {IDLE, RUN, DONE}, 2-bit encoding;
  - default WIDTH constant;
  - counter width constant = $clog2(WIDTH).
- One sub-module, rca_adder:
  - WIDTH-bit ripple-carry adder instantiating WIDTH full-adder cells; purely combinational.
  - Ports: x, y, cin (tied 0), sum, cout.
- The FSM, counter and acc shift register live in seq_mult16_ctrl.

Test Plan:
- Reset mid-RUN: accept a=0x1234, b=0x5678; assert rst at cycle 5 -> next cycle out_valid=0, in_ready=1, p=0; a new op with a=3, b=5 then yields p=0x0000000F.
- Basic product: a=0x1234, b=0x5678, out_ready=1 -> out_valid exactly 17 cycles after accept; p=0x06260060; in_ready returns 1 the cycle after hand-off.
- Carry stress: a=0xFFFF, b=0xFFFF -> p=0xFFFE0001; a=0x8000, b=0x0002 -> p=0x00010000.
- Back-pressure: a=7, b=9, out_ready=0 for 10 cycles after out_valid -> p=0x3F stable, out_valid held, in_ready=0, and in_valid pulses with a=1, b=1 are ignored; out_ready=1 -> one hand-off only.
- Zero operands: a=0, b=0xABCD -> p=0. With SEQ_MULT_ZERO_BYPASS_EN defined, out_valid arrives 1 cycle after accept; undefined, it arrives after 17 cycles.
- Back-to-back stream: 1000 random operand pairs with out_ready=1 and in_valid always high -> every p matches the a*b reference model; spacing between accepts is exactly 18 cycles.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the iterative shift-and-add multiplier.
package seq_mult_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    localparam int unsigned CNT_W = cnt_width(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mult16_ctrl_rca_adder.sv
// Combinational WIDTH-bit ripple-carry adder built from full-adder cells.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module rca_adder
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder u_fa (
            .a  (x[i]),
            .b  (y[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    assign cout = carry[WIDTH];
endmodule

// File: rtl/seq_mult16_ctrl.sv
// Iterative unsigned WIDTH x WIDTH shift-and-add multiplier with valid/ready on both sides.
// Optional SEQ_MULT_ZERO_BYPASS_EN: zero operands jump straight from IDLE to DONE.
module seq_mult16_ctrl
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);
    localparam int unsigned CW = cnt_width(WIDTH);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   mcand, addend, sum;
    logic               cout;
    logic [2*WIDTH-1:0] acc, acc_shift;
    logic [CW-1:0]      cnt;
    logic               accept, hand_off, zero_op;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign hand_off  = out_valid && out_ready;

`ifdef SEQ_MULT_ZERO_BYPASS_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    assign addend = acc[0] ? mcand : '0;

    rca_adder #(.WIDTH(WIDTH)) u_adder (
        .x    (acc[2*WIDTH-1:WIDTH]),
        .y    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // Carry-out becomes the new MSB as the accumulator shifts right.
    assign acc_shift = {cout, sum, acc[WIDTH-1:1]};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = zero_op ? DONE : RUN;
            RUN:     if (cnt == '0) state_nxt = DONE;
            DONE:    if (hand_off) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
            p     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand <= a;
                        acc   <= {{WIDTH{1'b0}}, b};
                        cnt   <= CW'(WIDTH - 1);
                        if (zero_op) begin
                            acc <= '0;
                            p   <= '0;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_shift;
                    if (cnt == '0) p <= acc_shift;
                    else           cnt <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mult16_ctrl.sv
// Directed self-checking bench for seq_mult16_ctrl (WIDTH=16).
module tb_seq_mult16_ctrl;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] a, b;
    logic [31:0] p;

    int n_checks = 0;
    int n_fail   = 0;

    seq_mult16_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands until accepted; returns the accept edge time.
    // Operands are scrambled right after accept to prove they were latched.
    task automatic accept_op(input logic [15:0] av, input logic [15:0] bv,
                             input bit keep_valid, output time t_acc);
        int k;
        @(negedge clk);
        in_valid = 1'b1;
        a = av;
        b = bv;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check_eq("accept_timeout", 0, 1);
        @(posedge clk);
        t_acc = $time;
        #1;
        in_valid = keep_valid;
        a = ~av;
        b = ~bv;
    endtask

    // Counts cycles after accept until out_valid is seen (first negedge = 1).
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        if (!out_valid) check_eq("result_timeout", 0, 1);
    endtask

    task automatic take_result(input string tag, input logic [31:0] exp_p);
        check_eq(tag, p, exp_p);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check_eq("handoff_out_valid", out_valid, 0);
        check_eq("handoff_in_ready", in_ready, 1);
    endtask

    initial begin
        time         t0, t1;
        int          lat;
        logic [15:0] ra, rb;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_p", p, 0);

        // Reset in the middle of RUN abandons the operation.
        accept_op(16'h1234, 16'h5678, 1'b0, t0);
        repeat (4) @(negedge clk);
        check_eq("midrun_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_in_ready", in_ready, 1);
        check_eq("midrst_p", p, 0);
        check_eq("midrst_busy", busy, 0);
        accept_op(16'd3, 16'd5, 1'b0, t0);
        wait_result(lat);
        take_result("after_rst_p", 32'h0000_000F);

        // Basic product and latency.
        accept_op(16'h1234, 16'h5678, 1'b0, t0);
        wait_result(lat);
        check_eq("basic_latency", lat, 17);
        check_eq("basic_busy", busy, 1);
        check_eq("basic_in_ready", in_ready, 0);
        take_result("basic_p", 32'h0626_0060);
        check_eq("basic_p_retained", p, 32'h0626_0060);

        // Carry-out stress.
        accept_op(16'hFFFF, 16'hFFFF, 1'b0, t0);
        wait_result(lat);
        take_result("ffff_sq_p", 32'hFFFE_0001);
        accept_op(16'h8000, 16'h0002, 1'b0, t0);
        wait_result(lat);
        take_result("msb_x2_p", 32'h0001_0000);

        // Back-pressure with ignored input pulses.
        accept_op(16'd7, 16'd9, 1'b0, t0);
        wait_result(lat);
        for (int k = 0; k < 10; k++) begin
            check_eq("bp_p", p, 32'h0000_003F);
            check_eq("bp_out_valid", out_valid, 1);
            check_eq("bp_in_ready", in_ready, 0);
            in_valid = k[0];
            a = 16'd1;
            b = 16'd1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        take_result("bp_final_p", 32'h0000_003F);
        repeat (3) begin
            @(negedge clk);
            check_eq("bp_single_handoff", out_valid, 0);
            check_eq("bp_p_retained", p, 32'h0000_003F);
        end

        // Zero operand.
        accept_op(16'h0000, 16'hABCD, 1'b0, t0);
        wait_result(lat);
`ifdef SEQ_MULT_ZERO_BYPASS_EN
        check_eq("zero_latency", lat, 1);
`else
        check_eq("zero_latency", lat, 17);
`endif
        take_result("zero_p", 32'h0000_0000);

        // Back-to-back random stream.
        out_ready = 1'b1;
        t1 = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i == 0) begin ra = 16'hFFFF; rb = 16'h0001; end
            accept_op(ra, rb, 1'b1, t0);
            if (i > 0) check_eq("stream_spacing", (t0 - t1) / 10, 18);
            t1 = t0;
            wait_result(lat);
            check_eq("stream_p", p, {16'h0, ra} * {16'h0, rb});
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
